// File: rtl/clock_controller_if.sv
// Control/status bundle for the run/halt/single-step clock sequencer.
// Optional tick-counter signals exist only when CLKCTL_TICK_COUNT_EN is defined.
interface clock_controller_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
);
    logic             i_run;
    logic             i_halt;
    logic             i_step;
    logic [DIV_W-1:0] i_div;
    logic             o_tick;
    logic             o_running;
    logic             o_halted;
`ifdef CLKCTL_TICK_COUNT_EN
    logic             i_clr_count;
    logic [CNT_W-1:0] o_tick_count;
`endif

`ifdef CLKCTL_TICK_COUNT_EN
    // Board / bench side: issues commands, observes status.
    modport master (
        output i_run, i_halt, i_step, i_div, i_clr_count,
        input  o_tick, o_running, o_halted, o_tick_count
    );
    // Sequencer side.
    modport slave (
        input  i_run, i_halt, i_step, i_div, i_clr_count,
        output o_tick, o_running, o_halted, o_tick_count
    );
`else
    // Board / bench side: issues commands, observes status.
    modport master (
        output i_run, i_halt, i_step, i_div,
        input  o_tick, o_running, o_halted
    );
    // Sequencer side.
    modport slave (
        input  i_run, i_halt, i_step, i_div,
        output o_tick, o_running, o_halted
    );
`endif
endinterface

// File: rtl/clock_controller.sv
// Run/halt/single-step sequencer producing a registered one-cycle clock-enable
// pulse (o_tick) every i_div+1 cycles while running.
// Optional feature macro: CLKCTL_TICK_COUNT_EN adds a wrapping tick counter
// with a clear input (clear wins over a coincident tick).
module clock_controller #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    clock_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;

    // Next-state logic; command priority is halt > run > step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            S_HALT: begin
                if (bus.i_halt) begin
                    state_d = S_HALT;
                end else if (bus.i_run) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (bus.i_step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (bus.i_halt) begin
                    // A tick that would have fired this edge is dropped.
                    state_d = S_HALT;
                    cnt_d   = '0;
                end else if (cnt_q >= bus.i_div) begin
                    // ">=" lets a lowered ratio tick at once instead of wrapping.
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
                tick_d  = !bus.i_halt;
            end
            default: begin
                state_d = S_HALT;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CLKCTL_TICK_COUNT_EN
    localparam logic [CNT_W-1:0] TCNT_ONE = CNT_W'(1);
    logic [CNT_W-1:0] tick_count_q, tick_count_d;

    // Counter tracks the tick being registered, so it reads N in the cycle
    // the Nth o_tick is high; clear takes precedence.
    always_comb begin
        tick_count_d = tick_count_q;
        if (bus.i_clr_count)
            tick_count_d = '0;
        else if (tick_d)
            tick_count_d = tick_count_q + TCNT_ONE;
    end

    assign bus.o_tick_count = tick_count_q;
`endif

    // State, divider count and outputs; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HALT;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
`ifdef CLKCTL_TICK_COUNT_EN
            tick_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
`ifdef CLKCTL_TICK_COUNT_EN
            tick_count_q <= tick_count_d;
`endif
        end
    end

    assign bus.o_tick    = tick_q;
    assign bus.o_running = (state_q == S_RUN);
    assign bus.o_halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller: reset, run at several ratios, halt,
// single step, held step, live ratio change, mid-run reset, and (with
// CLKCTL_TICK_COUNT_EN) the tick counter with CNT_W=4.
module tb_clock_controller;

    localparam int DIV_W = 16;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    clock_controller_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    clock_controller #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collect o_tick over n cycles, sample i into bit i.
    task automatic collect(input int n, output logic [31:0] pat);
        pat = '0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            pat[i] = bus.o_tick;
        end
    endtask

    logic [31:0] pat;
    int          nt;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.i_run  = 1'b0;
        bus.i_halt = 1'b0;
        bus.i_step = 1'b0;
        bus.i_div  = '0;
`ifdef CLKCTL_TICK_COUNT_EN
        bus.i_clr_count = 1'b0;
`endif
        cyc(3);
        reset = 1'b0;

        // 1. reset state and idle
        chk("rst_halted",  32'(bus.o_halted),  32'd1);
        chk("rst_running", 32'(bus.o_running), 32'd0);
        chk("rst_tick",    32'(bus.o_tick),    32'd0);
`ifdef CLKCTL_TICK_COUNT_EN
        chk("rst_count",   32'(bus.o_tick_count), 32'd0);
`endif
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            nt += int'(bus.o_tick);
        end
        chk("idle_ticks", 32'(nt), 32'd0);

        // halt beats run when both asserted
        bus.i_run = 1'b1; bus.i_halt = 1'b1;
        cyc(1);
        bus.i_run = 1'b0; bus.i_halt = 1'b0;
        chk("prio_halted", 32'(bus.o_halted), 32'd1);

        // 2. i_div=0: tick every cycle after the first RUN cycle
        bus.i_div = 16'd0;
        bus.i_run = 1'b1;
        cyc(1);
        bus.i_run = 1'b0;
        chk("div0_running", 32'(bus.o_running), 32'd1);
        chk("div0_tick0",   32'(bus.o_tick),    32'd0);
        collect(6, pat);
        chk("div0_pattern", pat, 32'h3f);
        bus.i_halt = 1'b1;
        cyc(1);
        bus.i_halt = 1'b0;
        chk("div0_halt_tick",   32'(bus.o_tick),   32'd0);
        chk("div0_halt_halted", 32'(bus.o_halted), 32'd1);

        // 3. i_div=3: period 4, first tick 4 cycles after run edge
        bus.i_div = 16'd3;
        bus.i_run = 1'b1;
        cyc(1);
        bus.i_run = 1'b0;
        collect(12, pat);
        chk("div3_pattern", pat, 32'h888);
        bus.i_halt = 1'b1;
        cyc(1);
        bus.i_halt = 1'b0;
        chk("div3_halted", 32'(bus.o_halted), 32'd1);
        collect(8, pat);
        chk("div3_after_halt", pat, 32'h0);

        // 4. single step: tick 2 edges after the pulse edge
        bus.i_step = 1'b1;
        cyc(1);
        bus.i_step = 1'b0;
        chk("step_tick_early", 32'(bus.o_tick), 32'd0);
        cyc(1);
        chk("step_tick",       32'(bus.o_tick),   32'd1);
        chk("step_halted",     32'(bus.o_halted), 32'd1);
        collect(5, pat);
        chk("step_once_only", pat, 32'h0);

        // held step: one tick every 2 cycles
        bus.i_step = 1'b1;
        collect(6, pat);
        bus.i_step = 1'b0;
        chk("step_held", pat, 32'h2a);
        cyc(1);

        // step ignored while running
        bus.i_div = 16'd3;
        bus.i_run = 1'b1;
        cyc(1);
        bus.i_run  = 1'b0;
        bus.i_step = 1'b1;
        collect(8, pat);
        bus.i_step = 1'b0;
        chk("run_step_ignored", pat, 32'h88);
        chk("run_still_running", 32'(bus.o_running), 32'd1);
        bus.i_halt = 1'b1;
        cyc(1);
        bus.i_halt = 1'b0;

        // 5. lower ratio below current count mid-run
        bus.i_div = 16'd9;
        bus.i_run = 1'b1;
        cyc(1);
        bus.i_run = 1'b0;
        cyc(7);
        chk("div9_no_tick_cnt7", 32'(bus.o_tick), 32'd0);
        bus.i_div = 16'd2;
        cyc(1);
        chk("div_lower_tick", 32'(bus.o_tick), 32'd1);
        collect(6, pat);
        chk("div2_pattern", pat, 32'h24);

        // reset on the edge that would have ticked
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("rst_run_tick",    32'(bus.o_tick),    32'd0);
        chk("rst_run_halted",  32'(bus.o_halted),  32'd1);
        chk("rst_run_running", 32'(bus.o_running), 32'd0);
        reset = 1'b0;

        // reset while in STEP drops the step tick
        bus.i_step = 1'b1;
        cyc(1);
        bus.i_step = 1'b0;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst_step_tick", 32'(bus.o_tick), 32'd0);
        collect(3, pat);
        chk("rst_step_quiet", pat, 32'h0);

        // halt in STEP aborts the tick
        bus.i_step = 1'b1;
        cyc(1);
        bus.i_step = 1'b0;
        bus.i_halt = 1'b1;
        collect(2, pat);
        bus.i_halt = 1'b0;
        chk("step_abort", pat, 32'h0);

`ifdef CLKCTL_TICK_COUNT_EN
        // 6. tick counter (count starts from 0 after the last reset)
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_step = 1'b1;
            cyc(1);
            bus.i_step = 1'b0;
            cyc(1);
        end
        chk("count_5", 32'(bus.o_tick_count), 32'd5);
        bus.i_step = 1'b1;
        cyc(1);
        bus.i_step = 1'b0;
        bus.i_clr_count = 1'b1;
        cyc(1);
        bus.i_clr_count = 1'b0;
        chk("clr_tick_seen", 32'(bus.o_tick),       32'd1);
        chk("clr_wins",      32'(bus.o_tick_count), 32'd0);
        bus.i_div = 16'd0;
        bus.i_run = 1'b1;
        cyc(1);
        bus.i_run = 1'b0;
        cyc(17);
        bus.i_halt = 1'b1;
        cyc(1);
        bus.i_halt = 1'b0;
        chk("count_wrap", 32'(bus.o_tick_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
